// File: rtl/vga_pkg.sv
// Shared definitions for the VGA rectangle-fill engine.
// Holds the default register base addresses, register offsets, frame size,
// CTRL bit positions and the fill FSM state encoding.
package vga_pkg;

    // Default base addresses of the VGA peripheral and of the filler.
    localparam logic [7:0] DEF_VGA_BASE  = 8'hB0;
    localparam logic [7:0] DEF_FILL_BASE = 8'hB4;

    // VGA peripheral register offsets.
    localparam logic [7:0] VGA_OFF_X   = 8'd0;
    localparam logic [7:0] VGA_OFF_Y   = 8'd1;
    localparam logic [7:0] VGA_OFF_COL = 8'd2;

    // Filler register offsets.
    localparam logic [7:0] FILL_OFF_X0   = 8'd0;
    localparam logic [7:0] FILL_OFF_Y0   = 8'd1;
    localparam logic [7:0] FILL_OFF_W    = 8'd2;
    localparam logic [7:0] FILL_OFF_H    = 8'd3;
    localparam logic [7:0] FILL_OFF_CTRL = 8'd4;

    // Visible frame size.
    localparam int unsigned DEF_FRAME_W = 160;
    localparam int unsigned DEF_FRAME_H = 120;

    // CTRL register bit positions.
    localparam int unsigned CTRL_COLOUR    = 0;
    localparam int unsigned CTRL_CLR_DROP  = 6;
    localparam int unsigned CTRL_START     = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WR_X,
        S_WR_Y,
        S_WR_COL,
        S_WR_COMMIT,
        S_WR_CLEAR
    } fill_state_t;

endpackage

// File: rtl/vga_rect_filler.sv
// Rectangle-fill engine sitting between the CPU bus and the VGA peripheral.
// When idle, CPU writes to the VGA registers are forwarded one cycle later.
// When started, it owns the VGA port and emits the X/Y/colour/commit/clear
// write sequence for every visible pixel of a clipped W x H rectangle.
//
// Ports:
//   CLK       system clock
//   RESET     asynchronous active-high reset
//   BUS_DATA  CPU data bus; driven only while CTRL is being read
//   BUS_ADDR  CPU address
//   BUS_WE    CPU write enable
//   VGA_ADDR  address to the VGA peripheral (registered)
//   VGA_DATA  data to the VGA peripheral (registered)
//   VGA_WE    write enable to the VGA peripheral (registered)
//   BUSY      high while a fill is in progress
module vga_rect_filler
    import vga_pkg::*;
#(
    parameter logic [7:0]  VGA_BASE  = DEF_VGA_BASE,
    parameter logic [7:0]  FILL_BASE = DEF_FILL_BASE,
    parameter int unsigned FRAME_W   = DEF_FRAME_W,
    parameter int unsigned FRAME_H   = DEF_FRAME_H
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic [7:0] VGA_ADDR,
    output logic [7:0] VGA_DATA,
    output logic       VGA_WE,
    output logic       BUSY
);

    localparam logic [8:0] FW = 9'(FRAME_W);
    localparam logic [8:0] FH = 9'(FRAME_H);

    // CPU-visible filler registers
    logic [7:0] x0_reg, w_reg, h_reg;
    logic [6:0] y0_reg;
    logic       drop;

    // Parameters latched at start
    logic [7:0] fx0, fw, fh;
    logic [6:0] fy0;
    logic       fcol;

    logic [7:0]  cx, cy;
    logic        busy;
    fill_state_t state;

    logic       vga_hit, ctrl_hit, vga_wr, ctrl_wr, start_req;
    logic [8:0] px, py;
    logic       visible, row_end, last_pixel;

    assign vga_hit   = (BUS_ADDR >= VGA_BASE) && (BUS_ADDR <= VGA_BASE + VGA_OFF_COL);
    assign ctrl_hit  = (BUS_ADDR == FILL_BASE + FILL_OFF_CTRL);
    assign vga_wr    = BUS_WE && vga_hit;
    assign ctrl_wr   = BUS_WE && ctrl_hit;
    assign start_req = ctrl_wr && BUS_DATA[CTRL_START];

    assign px         = 9'(fx0) + 9'(cx);
    assign py         = 9'(fy0) + 9'(cy);
    assign visible    = (px < FW) && (py < FH);
    assign row_end    = (cx == fw - 8'd1);
    assign last_pixel = row_end && (cy == fh - 8'd1);

    assign BUS_DATA = (!BUS_WE && ctrl_hit) ? {busy, drop, 6'b0} : 'z;
    assign BUSY     = busy;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x0_reg   <= '0;
            y0_reg   <= '0;
            w_reg    <= '0;
            h_reg    <= '0;
            drop     <= 1'b0;
            fx0      <= '0;
            fy0      <= '0;
            fw       <= '0;
            fh       <= '0;
            fcol     <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
            VGA_ADDR <= '0;
            VGA_DATA <= '0;
            VGA_WE   <= 1'b0;
        end else begin
            if (BUS_WE) begin
                if (BUS_ADDR == FILL_BASE + FILL_OFF_X0) x0_reg <= BUS_DATA;
                if (BUS_ADDR == FILL_BASE + FILL_OFF_Y0) y0_reg <= BUS_DATA[6:0];
                if (BUS_ADDR == FILL_BASE + FILL_OFF_W)  w_reg  <= BUS_DATA;
                if (BUS_ADDR == FILL_BASE + FILL_OFF_H)  h_reg  <= BUS_DATA;
            end

            if (vga_wr && busy)
                drop <= 1'b1;
            else if (ctrl_wr && BUS_DATA[CTRL_CLR_DROP])
                drop <= 1'b0;

            // Outputs are registered: each transition loads the VGA write
            // belonging to the state being entered.
            unique case (state)
                S_IDLE: begin
                    if (start_req && w_reg != 8'd0 && h_reg != 8'd0) begin
                        fx0    <= x0_reg;
                        fy0    <= y0_reg;
                        fw     <= w_reg;
                        fh     <= h_reg;
                        fcol   <= BUS_DATA[CTRL_COLOUR];
                        cx     <= '0;
                        cy     <= '0;
                        busy   <= 1'b1;
                        state  <= S_CHECK;
                        VGA_WE <= 1'b0;
                    end else if (vga_wr) begin
                        VGA_ADDR <= BUS_ADDR;
                        VGA_DATA <= BUS_DATA;
                        VGA_WE   <= 1'b1;
                    end else begin
                        VGA_WE <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (visible) begin
                        VGA_ADDR <= VGA_BASE + VGA_OFF_X;
                        VGA_DATA <= px[7:0];
                        VGA_WE   <= 1'b1;
                        state    <= S_WR_X;
                    end else begin
                        cx <= row_end ? 8'd0 : cx + 8'd1;
                        if (row_end) cy <= cy + 8'd1;
                        if (last_pixel) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                S_WR_X: begin
                    VGA_ADDR <= VGA_BASE + VGA_OFF_Y;
                    VGA_DATA <= {1'b0, py[6:0]};
                    state    <= S_WR_Y;
                end
                S_WR_Y: begin
                    VGA_ADDR <= VGA_BASE + VGA_OFF_COL;
                    VGA_DATA <= {7'b0, fcol};
                    state    <= S_WR_COL;
                end
                S_WR_COL: begin
                    VGA_ADDR <= VGA_BASE + VGA_OFF_Y;
                    VGA_DATA <= {1'b1, py[6:0]};
                    state    <= S_WR_COMMIT;
                end
                S_WR_COMMIT: begin
                    VGA_ADDR <= VGA_BASE + VGA_OFF_Y;
                    VGA_DATA <= {1'b0, py[6:0]};
                    state    <= S_WR_CLEAR;
                end
                S_WR_CLEAR: begin
                    VGA_WE <= 1'b0;
                    cx <= row_end ? 8'd0 : cx + 8'd1;
                    if (row_end) cy <= cy + 8'd1;
                    if (last_pixel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_CHECK;
                    end
                end
                default: begin
                    busy   <= 1'b0;
                    VGA_WE <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Self-checking bench for vga_rect_filler: table-driven pass-through and
// fill vectors plus hand-written sequences for DROP handling and reset.
module tb_vga_rect_filler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_we = 1'b0;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    wire  [7:0] bus_data;
    logic [7:0] vga_addr, vga_data;
    logic       vga_we, busy;

    assign bus_data = drv_en ? drv : 8'hzz;

    vga_rect_filler #(
        .VGA_BASE (8'hB0),
        .FILL_BASE(8'hB4),
        .FRAME_W  (160),
        .FRAME_H  (120)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .BUS_DATA(bus_data),
        .BUS_ADDR(bus_addr),
        .BUS_WE  (bus_we),
        .VGA_ADDR(vga_addr),
        .VGA_DATA(vga_data),
        .VGA_WE  (vga_we),
        .BUSY    (busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] cap_q[$];
    logic [15:0] exp_q[$];
    int          busy_cnt = 0;
    logic        cap_en = 1'b0;

    always @(negedge clk) begin
        if (cap_en) begin
            if (vga_we) cap_q.push_back({vga_addr, vga_data});
            if (busy) busy_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_addr = a; drv = d; drv_en = 1'b1; bus_we = 1'b1;
        @(negedge clk);
        bus_we = 1'b0; drv_en = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic read_ctrl(input string name, input logic [7:0] exp);
        @(negedge clk);
        bus_addr = 8'hB8; bus_we = 1'b0; drv_en = 1'b0;
        #1 check(name, {24'h0, bus_data}, {24'h0, exp});
        bus_addr = 8'h00;
    endtask

    // Expected write list for a fill, generated pixel by pixel in raster order.
    task automatic build_exp(input int x0, input int y0, input int w, input int h, input logic col);
        exp_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                int px;
                int py;
                logic [7:0] pxb;
                logic [7:0] pyb;
                px = x0 + x;
                py = (y0 % 128) + y;
                pxb = px[7:0];
                pyb = {1'b0, py[6:0]};
                if (px < 160 && py < 120) begin
                    exp_q.push_back({8'hB0, pxb});
                    exp_q.push_back({8'hB1, pyb});
                    exp_q.push_back({8'hB2, 7'b0, col});
                    exp_q.push_back({8'hB1, pyb | 8'h80});
                    exp_q.push_back({8'hB1, pyb});
                end
            end
        end
    endtask

    task automatic start_fill(input logic [7:0] x0, y0, w, h, ctrl);
        cpu_write(8'hB4, x0);
        cpu_write(8'hB5, y0);
        cpu_write(8'hB6, w);
        cpu_write(8'hB7, h);
        cap_q.delete();
        busy_cnt = 0;
        cap_en = 1'b1;
        cpu_write(8'hB8, ctrl);
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_timeout"}, {31'h0, ok}, 32'h1);
        @(negedge clk);
        cap_en = 1'b0;
    endtask

    task automatic compare_fill(input string name, input int exp_busy);
        int n;
        check({name, "_nwrites"}, cap_q.size(), exp_q.size());
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wr%0d", name, i), {16'h0, cap_q[i]}, {16'h0, exp_q[i]});
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
    } pt_vec_t;

    typedef struct {
        logic [7:0] x0, y0, w, h, ctrl;
        int         exp_busy;
    } fill_vec_t;

    pt_vec_t   pt[5];
    fill_vec_t fv[4];

    initial begin
        pt[0] = '{8'hB0, 8'h05, 1'b1, 8'hB0, 8'h05};
        pt[1] = '{8'hB1, 8'h3C, 1'b1, 8'hB1, 8'h3C};
        pt[2] = '{8'hB2, 8'h01, 1'b1, 8'hB2, 8'h01};
        pt[3] = '{8'h40, 8'h12, 1'b0, 8'h00, 8'h00};
        pt[4] = '{8'hB4, 8'h09, 1'b0, 8'h00, 8'h00};

        fv[0] = '{8'd2,   8'd3,   8'd2, 8'd1, 8'h81, 12};
        fv[1] = '{8'd158, 8'd0,   8'd4, 8'd1, 8'h81, 14};
        fv[2] = '{8'd0,   8'd118, 8'd1, 8'd4, 8'h80, 14};
        fv[3] = '{8'd159, 8'd119, 8'd3, 8'd3, 8'h81, 14};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_vga_we", {31'h0, vga_we}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_vga_addr", {24'h0, vga_addr}, 32'h0);
        check("rst_vga_data", {24'h0, vga_data}, 32'h0);
        rst = 1'b0;
        read_ctrl("rst_ctrl_read", 8'h00);

        // Idle pass-through
        foreach (pt[i]) begin
            cpu_write(pt[i].addr, pt[i].data);
            check($sformatf("pt%0d_we", i), {31'h0, vga_we}, {31'h0, pt[i].exp_we});
            if (pt[i].exp_we) begin
                check($sformatf("pt%0d_addr", i), {24'h0, vga_addr}, {24'h0, pt[i].exp_addr});
                check($sformatf("pt%0d_data", i), {24'h0, vga_data}, {24'h0, pt[i].exp_data});
            end
        end

        // Fills, including horizontal / vertical / corner clipping
        foreach (fv[i]) begin
            build_exp(fv[i].x0, fv[i].y0, fv[i].w, fv[i].h, fv[i].ctrl[0]);
            start_fill(fv[i].x0, fv[i].y0, fv[i].w, fv[i].h, fv[i].ctrl);
            check($sformatf("fill%0d_busy_rise", i), {31'h0, busy}, 32'h1);
            wait_idle($sformatf("fill%0d", i));
            compare_fill($sformatf("fill%0d", i), fv[i].exp_busy);
        end

        // Blocked VGA write during a fill sets DROP and is not forwarded
        build_exp(10, 10, 3, 2, 1'b0);
        start_fill(8'd10, 8'd10, 8'd3, 8'd2, 8'h80);
        read_ctrl("drop_ctrl_busy", 8'h80);
        cpu_write(8'hB2, 8'h01);
        read_ctrl("drop_ctrl_set", 8'hC0);
        wait_idle("dropfill");
        compare_fill("dropfill", 36);
        read_ctrl("drop_ctrl_sticky", 8'h40);

        // Start together with DROP clear, then set and clear DROP mid-fill
        build_exp(10, 10, 3, 2, 1'b0);
        cap_q.delete();
        busy_cnt = 0;
        cap_en = 1'b1;
        cpu_write(8'hB8, 8'hC0);
        read_ctrl("startclr_ctrl", 8'h80);
        cpu_write(8'hB1, 8'h22);
        read_ctrl("startclr_redrop", 8'hC0);
        cpu_write(8'hB8, 8'h40);
        wait_idle("startclr");
        compare_fill("startclr", 36);
        read_ctrl("clr_ctrl_after", 8'h00);

        // Zero width start never raises BUSY
        cpu_write(8'hB6, 8'd0);
        cpu_write(8'hB7, 8'd2);
        cpu_write(8'hB8, 8'h81);
        check("w0_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("w0_busy_later", {31'h0, busy}, 32'h0);
        check("w0_we", {31'h0, vga_we}, 32'h0);

        // Reset during the colour write of a pixel
        begin
            logic found;
            found = 1'b0;
            start_fill(8'd5, 8'd6, 8'd1, 8'd1, 8'h81);
            cap_en = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (vga_we && vga_addr == 8'hB2) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("rstmid_reach_wr_col", {31'h0, found}, 32'h1);
            rst = 1'b1;
            #1;
            check("rstmid_we", {31'h0, vga_we}, 32'h0);
            check("rstmid_busy", {31'h0, busy}, 32'h0);
            @(negedge clk);
            rst = 1'b0;
            read_ctrl("rstmid_ctrl", 8'h00);
            // Registers were cleared, so W=0 and a start must be ignored
            cpu_write(8'hB8, 8'h80);
            check("rstmid_regs_cleared", {31'h0, busy}, 32'h0);
            // FSM idle: pass-through works again
            cpu_write(8'hB0, 8'h07);
            check("rstmid_pt_we", {31'h0, vga_we}, 32'h1);
            check("rstmid_pt", {16'h0, vga_addr, vga_data}, 32'h0000B007);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vga_rect_filler.md
# vga_rect_filler

Rectangle-fill engine for the VGA peripheral. It sits between the CPU data bus and the VGA peripheral's bus port. When idle, it forwards CPU writes to the VGA registers (X at 0xB0, Y at 0xB1, colour at 0xB2). When started, it takes ownership of that port and generates the per-pixel register-write sequence that fills a clipped W×H rectangle in the 160×120 frame buffer.

## Interface
Parameters:
- VGA_BASE, 8'hB0: VGA peripheral registers (X = base, Y = base+1, colour = base+2).
- FILL_BASE, 8'hB4: filler registers (X0, Y0, W, H, CTRL at base..base+4).
- FRAME_W, 160: visible columns.
- FRAME_H, 120: visible rows.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  CPU data bus. Driven only during a CTRL read, otherwise high-Z.
- BUS_ADDR  in  8  CPU address.
- BUS_WE  in  1  CPU write enable.
- VGA_ADDR  out  8  address to the VGA peripheral.
- VGA_DATA  out  8  data to the VGA peripheral.
- VGA_WE  out  1  write enable to the VGA peripheral.
- BUSY  out  1  high while a fill is in progress.

## Operation
Register map:
- FILL_BASE+0: X0 (8 bits).
- FILL_BASE+1: Y0 (7 bits; bit 7 is ignored).
- FILL_BASE+2: W (8 bits).
- FILL_BASE+3: H (8 bits).
- FILL_BASE+4 (CTRL) write:
  - bit0: colour.
  - bit6: clears DROP.
  - bit7: start. Ignored while BUSY.
- FILL_BASE+4 (CTRL) read: {BUSY, DROP, 6'b0}, driven onto BUS_DATA in the same cycle that BUS_WE=0 and the address matches.

Pass-through (IDLE only):
- A CPU write to VGA_BASE..VGA_BASE+2 is registered and presented one cycle later on VGA_ADDR/VGA_DATA with VGA_WE=1.

Writes while busy:
- A CPU write to VGA_BASE..VGA_BASE+2 while BUSY is not forwarded.
- Such a write sets the sticky DROP flag.

FSM states: IDLE, CHECK, WR_X, WR_Y, WR_COL, WR_COMMIT, WR_CLEAR.
- IDLE → CHECK on start when W≠0 and H≠0. Counters load cx=0, cy=0.
- Start with W=0 or H=0 leaves the FSM in IDLE; BUSY never rises.
- CHECK computes px=X0+cx and py=Y0+cy as 9-bit sums.
  - If px<FRAME_W and py<FRAME_H: → WR_X.
  - Otherwise (clipped): advance the counters and stay in CHECK, or → IDLE if the rectangle is finished.
- Write sequence, one cycle each, VGA_WE=1:
  - WR_X: (VGA_BASE, px[7:0]).
  - WR_Y: (VGA_BASE+1, {1'b0, py[6:0]}).
  - WR_COL: (VGA_BASE+2, {7'b0, colour}).
  - WR_COMMIT: (VGA_BASE+1, {1'b1, py[6:0]}).
  - WR_CLEAR: (VGA_BASE+1, {1'b0, py[6:0]}).
- WR_CLEAR advances the counters: cx++, and on cx==W-1, cx=0 and cy++. It then returns to CHECK, or → IDLE when the last pixel (cx=W-1, cy=H-1) is done.
- Fill order is raster: x inner, y outer.
- X0, Y0, W, H and colour are latched at start. Register writes during a fill affect only the next fill.

## Timing
- Reset values: VGA_ADDR=0, VGA_DATA=0, VGA_WE=0, BUSY=0, DROP=0, all filler registers 0, FSM=IDLE, BUS_DATA high-Z.
- Start is sampled at edge N. BUSY=1 and the FSM is in CHECK from N+1.
- Each visible pixel takes 6 cycles (CHECK plus 5 writes). Each clipped pixel takes 1 cycle.
- BUSY drops in the cycle after the final CHECK or WR_CLEAR.
- A fully visible fill holds BUSY for 6·W·H cycles.
- VGA_WE is low in IDLE except for pass-through, low in CHECK, and high in every WR_* state.
- Pass-through latency is exactly 1 cycle. No pass-through write is emitted in the cycle after start.
- RESET asserted mid-fill: VGA_WE and BUSY go low immediately (asynchronous). A partial pixel is abandoned.
- Start and DROP-clear in the same CTRL write are both honoured.

## Structure
- Shared package vga_pkg:
  - VGA/fill address offsets.
  - FRAME_W/FRAME_H.
  - The FSM state enum.
  - The CTRL bit positions.
- No sub-modules. The pass-through mux and the FSM live in one module.

## Test plan
- Reset asserted → VGA_WE=0, BUSY=0, BUS_DATA high-Z. CTRL read returns 0x00.
- Idle CPU write (0xB0, 0x05) → next cycle VGA_ADDR=0xB0, VGA_DATA=0x05, VGA_WE=1.
- X0=2, Y0=3, W=2, H=1, CTRL=0x81 → write sequence (B0,02) (B1,03) (B2,01) (B1,83) (B1,03), then the same with X=03. BUSY high for 12 cycles.
- X0=158, W=4, H=1, Y0=0 → commits only x=158 and x=159. BUSY high for 14 cycles. No write with X≥160.
- CPU write (0xB2, 0x01) during a fill → not forwarded. CTRL read = 0xC0. Write CTRL=0x40 then read → 0x00 after the fill ends.
- Start with W=0 → BUSY stays 0. RESET pulse during WR_COL of a fill → VGA_WE=0 and BUSY=0 immediately, FSM back in IDLE.
